lsu_mem_port: RTL and testbench

Load/store requester that drives the word-wide data memory on behalf of the pipeline's memory stage. Accepts one byte/halfword/word load or store request at a time, converts byte addresses into word indices, performs sub-word stores as a read-modify-write, sign/zero-extends load data, and flags misaligned or out-of-range accesses without touching memory. Sits between the MEM-stage pipeline register and the data memory's read_addr/write_addr/write_en/write_data/read_data ports.

---
 rtl/lsu_mem_port_if.sv | 33 +++
 rtl/lsu_mem_port.sv | 140 ++++++++++++++
 tb/tb_lsu_mem_port.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_port_if.sv
// Pipeline request/response and data-memory signals of the load/store port.
// The slave modport is the LSU itself; master is the pipeline plus memory around it.
interface lsu_mem_port_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_read_addr;
    logic [31:0] mem_write_addr;
    logic        mem_write_en;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    modport slave (
        input  req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata,
        input  mem_read_data,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_read_addr, mem_write_addr, mem_write_en, mem_write_data
    );

    modport master (
        output req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata,
        output mem_read_data,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_read_addr, mem_write_addr, mem_write_en, mem_write_data
    );
endinterface

// File: rtl/lsu_mem_port.sv
// Single-outstanding load/store requester for a word-wide data memory with
// sub-word read-modify-write stores and sign/zero-extended loads.
module lsu_mem_port #(
    parameter int RAM_DEPTH = 1024,
    parameter int RAM_WIDTH = 32
) (
    input logic           clk,
    input logic           reset_b,
    lsu_mem_port_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCESS   = 2'd1,
        MERGE_WR = 2'd2,
        RESP     = 2'd3
    } state_t;

    localparam logic [29:0] DEPTH_LIMIT = 30'(RAM_DEPTH);
    localparam logic [1:0]  SIZE_BYTE   = 2'b00;
    localparam logic [1:0]  SIZE_HALF   = 2'b01;
    localparam logic [1:0]  SIZE_WORD   = 2'b10;

    state_t                 state, state_next;
    logic                   store_q, unsigned_q, err_q;
    logic [1:0]             size_q, lane_q;
    logic [29:0]            index_q;
    logic [RAM_WIDTH-1:0]   wdata_q, rdata_q, merge_q;
    logic                   accept, req_err;
    logic [7:0]             lane_byte;
    logic [15:0]            lane_half;
    logic [RAM_WIDTH-1:0]   load_data, merge_data;

    assign accept = bus.req_valid && (state == IDLE);

    always_comb begin
        req_err = (bus.req_size == 2'b11)
               || (bus.req_size == SIZE_HALF && bus.req_addr[0])
               || (bus.req_size == SIZE_WORD && bus.req_addr[1:0] != 2'b00)
               || (bus.req_addr[31:2] >= DEPTH_LIMIT);
    end

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) state <= IDLE;
        else          state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a value held (no latches).
    always_comb begin
        state_next         = state;
        bus.req_ready      = 1'b0;
        bus.rsp_valid      = 1'b0;
        bus.mem_write_en   = 1'b0;
        bus.mem_write_data = '0;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) state_next = req_err ? RESP : ACCESS;
            end
            ACCESS: begin
                if (!store_q) begin
                    state_next = RESP;
                end else if (size_q == SIZE_WORD) begin
                    bus.mem_write_en   = 1'b1;
                    bus.mem_write_data = wdata_q;
                    state_next         = RESP;
                end else begin
                    state_next = MERGE_WR;
                end
            end
            MERGE_WR: begin
                bus.mem_write_en   = 1'b1;
                bus.mem_write_data = merge_q;
                state_next         = RESP;
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                state_next    = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Lane extraction and extension for loads.
    always_comb begin
        lane_byte = bus.mem_read_data[{lane_q, 3'b000} +: 8];
        lane_half = lane_q[1] ? bus.mem_read_data[31:16] : bus.mem_read_data[15:0];
        case (size_q)
            SIZE_BYTE: load_data = unsigned_q ? {24'b0, lane_byte}
                                              : {{24{lane_byte[7]}}, lane_byte};
            SIZE_HALF: load_data = unsigned_q ? {16'b0, lane_half}
                                              : {{16{lane_half[15]}}, lane_half};
            default:   load_data = bus.mem_read_data;
        endcase
    end

    // Current memory word with the addressed lane replaced by store data.
    always_comb begin
        merge_data = bus.mem_read_data;
        if (size_q == SIZE_BYTE) merge_data[{lane_q, 3'b000} +: 8]     = wdata_q[7:0];
        else                     merge_data[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            store_q    <= 1'b0;
            unsigned_q <= 1'b0;
            err_q      <= 1'b0;
            size_q     <= 2'b00;
            lane_q     <= 2'b00;
            index_q    <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            merge_q    <= '0;
        end else begin
            if (accept) begin
                store_q    <= bus.req_store;
                unsigned_q <= bus.req_unsigned;
                err_q      <= req_err;
                size_q     <= bus.req_size;
                lane_q     <= bus.req_addr[1:0];
                wdata_q    <= bus.req_wdata;
                rdata_q    <= '0;
                // Faulting requests never present their address to memory.
                if (!req_err) index_q <= bus.req_addr[31:2];
            end
            if (state == ACCESS && !store_q)                       rdata_q <= load_data;
            if (state == ACCESS && store_q && size_q != SIZE_WORD) merge_q <= merge_data;
        end
    end

    assign bus.rsp_rdata      = (state == RESP) ? rdata_q : '0;
    assign bus.rsp_err        = (state == RESP) && err_q;
    assign bus.mem_read_addr  = {2'b00, index_q};
    assign bus.mem_write_addr = {2'b00, index_q};

endmodule

// File: tb/tb_lsu_mem_port.sv
// Scoreboard bench for lsu_mem_port: directed loads/stores/errors, reset in the
// middle of a read-modify-write, then random traffic against a reference memory.
module tb_lsu_mem_port;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          writes;
    } exp_t;

    logic clk = 1'b0;
    logic reset_b;
    lsu_mem_port_if bus ();

    lsu_mem_port #(.RAM_DEPTH(1024), .RAM_WIDTH(32)) dut (
        .clk     (clk),
        .reset_b (reset_b),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Behavioural data memory: combinational read, write on the rising edge.
    logic [31:0] mem [0:1023] = '{default: 32'h0};
    logic        pl_en = 1'b0;
    logic [9:0]  pl_addr = '0;
    logic [31:0] pl_data = '0;
    assign bus.mem_read_data = mem[bus.mem_read_addr[9:0]];
    always @(posedge clk) begin
        if (bus.mem_write_en)  mem[bus.mem_write_addr[9:0]] <= bus.mem_write_data;
        else if (pl_en)        mem[pl_addr] <= pl_data;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          wr_count = 0;
    logic [31:0] wr_addr_last = '0;
    logic [31:0] wr_data_last = '0;
    always @(negedge clk) begin
        if (bus.mem_write_en === 1'b1) begin
            wr_count++;
            wr_addr_last = bus.mem_write_addr;
            wr_data_last = bus.mem_write_data;
        end
    end

    logic [31:0] ref_mem [0:1023];
    exp_t        exp_q [$];
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, want);
        end
    endtask

    function automatic logic m_err(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'b11) || (sz == 2'b01 && a[0]) ||
               (sz == 2'b10 && a[1:0] != 2'b00) || (a[31:2] >= 30'd1024);
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] w, input logic [1:0] sz,
                                           input logic uns, input logic [31:0] a);
        logic [31:0] v;
        v = w >> {a[1:0], 3'b000};
        case (sz)
            2'b00: begin
                v = v & 32'h0000_00FF;
                if (!uns && v[7]) v = v | 32'hFFFF_FF00;
            end
            2'b01: begin
                v = v & 32'h0000_FFFF;
                if (!uns && v[15]) v = v | 32'hFFFF_0000;
            end
            default: v = w;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] m_store(input logic [31:0] w, input logic [1:0] sz,
                                            input logic [31:0] wd, input logic [31:0] a);
        logic [31:0] mask;
        logic [4:0]  sh;
        mask = (sz == 2'b00) ? 32'h0000_00FF : (sz == 2'b01) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        sh   = {a[1:0], 3'b000};
        return (w & ~(mask << sh)) | ((wd & mask) << sh);
    endfunction

    task automatic preload(input logic [9:0] idx, input logic [31:0] data);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = idx; pl_data = data;
        @(negedge clk);
        pl_en = 1'b0;
        ref_mem[idx] = data;
    endtask

    // Issue one request, then compare the response popped from the scoreboard.
    task automatic run_req(input logic st, input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
        exp_t e;
        int   start, wr0, waited;
        e.rdata  = exp_rdata;
        e.err    = exp_err;
        e.lat    = exp_lat;
        e.writes = (st && !exp_err) ? 1 : 0;
        exp_q.push_back(e);

        @(negedge clk);
        waited = 0;
        while (!bus.req_ready && waited < 16) begin
            @(negedge clk);
            waited++;
        end
        check("ready_before_req", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1; bus.req_store = st; bus.req_size = sz;
        bus.req_unsigned = uns; bus.req_addr = addr; bus.req_wdata = wd;
        start = cyc;
        wr0   = wr_count;

        @(negedge clk);
        bus.req_valid    = 1'b0;
        bus.req_store    = 1'($urandom_range(0, 1));
        bus.req_size     = 2'($urandom_range(0, 3));
        bus.req_unsigned = 1'($urandom_range(0, 1));
        bus.req_addr     = $urandom();
        bus.req_wdata    = $urandom();
        waited = 1;
        while (!bus.rsp_valid && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        e = exp_q.pop_front();
        if (!bus.rsp_valid) begin
            check("rsp_timeout", 32'(bus.rsp_valid), 32'd1);
            return;
        end
        check("rsp_rdata", bus.rsp_rdata, e.rdata);
        check("rsp_err", 32'(bus.rsp_err), 32'(e.err));
        check("latency", 32'(cyc - start), 32'(e.lat));
        check("write_cycles", 32'(wr_count - wr0), 32'(e.writes));
        @(negedge clk);
        check("rsp_single_pulse", 32'(bus.rsp_valid), 32'd0);
        check("ready_after_resp", 32'(bus.req_ready), 32'd1);
        if (st && !exp_err) ref_mem[addr[11:2]] = m_store(ref_mem[addr[11:2]], sz, wd, addr);
    endtask

    task automatic model_req(input logic st, input logic [1:0] sz, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wd);
        logic        err;
        logic [31:0] rd;
        int          lat;
        err = m_err(sz, addr);
        rd  = (err || st) ? 32'h0 : m_load(ref_mem[addr[11:2]], sz, uns, addr);
        lat = err ? 1 : (st && sz != 2'b10) ? 3 : 2;
        run_req(st, sz, uns, addr, wd, rd, err, lat);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr0;
        logic saw_rsp;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
        reset_b = 1'b0;
        bus.req_valid = 1'b0; bus.req_store = 1'b0; bus.req_size = 2'b00;
        bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        check("rst_write_en", 32'(bus.mem_write_en), 32'd0);
        check("rst_write_data", bus.mem_write_data, 32'd0);
        check("rst_read_addr", bus.mem_read_addr, 32'd0);
        check("rst_write_addr", bus.mem_write_addr, 32'd0);
        reset_b = 1'b1;

        preload(10'd5, 32'h8899_AABB);
        preload(10'd1023, 32'h8000_0000);

        run_req(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 32'h8899_AABB, 1'b0, 2);
        check("load_read_addr", bus.mem_read_addr, 32'd5);
        run_req(1'b0, 2'b00, 1'b0, 32'h17, 32'h0, 32'hFFFF_FF88, 1'b0, 2);
        run_req(1'b0, 2'b00, 1'b1, 32'h16, 32'h0, 32'h0000_0099, 1'b0, 2);
        run_req(1'b0, 2'b01, 1'b0, 32'h14, 32'h0, 32'hFFFF_AABB, 1'b0, 2);
        run_req(1'b0, 2'b01, 1'b1, 32'h16, 32'h0, 32'h0000_8899, 1'b0, 2);
        run_req(1'b0, 2'b00, 1'b0, 32'hFFF, 32'h0, 32'hFFFF_FF80, 1'b0, 2);

        run_req(1'b1, 2'b00, 1'b0, 32'h15, 32'hCAFE_0011, 32'h0, 1'b0, 3);
        check("byte_store_addr", wr_addr_last, 32'd5);
        check("byte_store_data", wr_data_last, 32'h8899_11BB);
        check("byte_store_mem", mem[5], 32'h8899_11BB);

        run_req(1'b1, 2'b10, 1'b0, 32'h20, 32'hDEAD_BEEF, 32'h0, 1'b0, 2);
        check("word_store_addr", wr_addr_last, 32'd8);
        run_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'hDEAD_BEEF, 1'b0, 2);
        run_req(1'b1, 2'b01, 1'b0, 32'h22, 32'h5555_1234, 32'h0, 1'b0, 3);
        run_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h1234_BEEF, 1'b0, 2);

        run_req(1'b0, 2'b01, 1'b0, 32'h15, 32'h0, 32'h0, 1'b1, 1);
        run_req(1'b1, 2'b10, 1'b0, 32'h22, 32'h1, 32'h0, 1'b1, 1);
        run_req(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, 1);
        run_req(1'b1, 2'b10, 1'b0, 32'h1000, 32'h2, 32'h0, 1'b1, 1);
        run_req(1'b1, 2'b00, 1'b0, 32'h1001, 32'h3, 32'h0, 1'b1, 1);

        // Reset while a byte store sits in ACCESS.
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_store = 1'b1; bus.req_size = 2'b00;
        bus.req_unsigned = 1'b0; bus.req_addr = 32'h14; bus.req_wdata = 32'h77;
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("rmw_busy", 32'(bus.req_ready), 32'd0);
        wr0 = wr_count;
        reset_b = 1'b0;
        #1;
        check("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("midrst_req_ready", 32'(bus.req_ready), 32'd1);
        check("midrst_write_en", 32'(bus.mem_write_en), 32'd0);
        check("midrst_write_data", bus.mem_write_data, 32'd0);
        check("midrst_read_addr", bus.mem_read_addr, 32'd0);
        check("midrst_rsp_rdata", bus.rsp_rdata, 32'd0);
        repeat (2) @(negedge clk);
        reset_b = 1'b1;
        saw_rsp = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus.rsp_valid) saw_rsp = 1'b1;
        end
        check("midrst_no_rsp", 32'(saw_rsp), 32'd0);
        check("midrst_no_write", 32'(wr_count - wr0), 32'd0);
        check("midrst_mem_intact", mem[5], 32'h8899_11BB);
        run_req(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 32'h8899_11BB, 1'b0, 2);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            a = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 9) == 0) a = a | 32'h0000_1000;
            model_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), a, $urandom());
        end
        for (int i = 0; i < 16; i++) check("final_mem", mem[i], ref_mem[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
